// File: rtl/cnn_conv1_pkg.sv
// cnn_conv1_pkg
//   Shared definitions for the conv1 MAC sequencer:
//   - FSM state type
//   - operand and result widths for the 14s x 9s multiplier
//   - output clamp limits
package cnn_conv1_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int X_W = 14;   // pixel operand
    localparam int W_W = 9;    // weight operand
    localparam int P_W = 23;   // product
    localparam int Y_W = 14;   // output pixel

    localparam int OUT_MAX = 8191;
    localparam int OUT_MIN = -8192;

endpackage

// File: rtl/cnn_conv1_round_sat.sv
// cnn_conv1_round_sat
//   Combinational output stage: round-half-up removal of FRAC_SHIFT
//   fractional bits, saturation to the signed 14-bit range and optional ReLU.
// Ports:
//   acc  in   ACC_W  signed accumulator value
//   y    out  14     signed result
module cnn_conv1_round_sat
    import cnn_conv1_pkg::*;
#(
    parameter int ACC_W      = 32,
    parameter int FRAC_SHIFT = 8,
    parameter int RELU       = 1
) (
    input  logic [ACC_W-1:0] acc,
    output logic [Y_W-1:0]   y
);

    localparam logic signed [ACC_W:0] HALF  = (ACC_W+1)'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_W:0] MAX_E = (ACC_W+1)'(OUT_MAX);
    localparam logic signed [ACC_W:0] MIN_E = (ACC_W+1)'(OUT_MIN);

    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] r;

    always_comb begin
        // One guard bit so adding the rounding constant can never wrap.
        sum = $signed({acc[ACC_W-1], acc}) + HALF;
        r   = sum >>> FRAC_SHIFT;
        if (r > MAX_E) begin
            y = Y_W'(OUT_MAX);
        end else if (r < MIN_E) begin
            y = Y_W'(OUT_MIN);
        end else begin
            y = r[Y_W-1:0];
        end
        if (RELU != 0 && r < 0) begin
            y = '0;
        end
    end

endmodule

// File: rtl/cnn_conv1_mac_ctrl.sv
// cnn_conv1_mac_ctrl
//   Computes one conv1 output pixel as bias + sum of NTAPS pixel*weight
//   products through an external combinational multiplier, then rounds,
//   saturates and optionally applies ReLU.
// Ports:
//   ap_clk, ap_rst_n          clock, async active-low reset
//   ap_start/done/idle/ready  block-level handshake
//   bias                      signed bias, captured on start
//   x_address0/x_ce0/x_q0     pixel memory port (1-cycle latency)
//   w_address0/w_ce0/w_q0     weight memory port (1-cycle latency)
//   mul_din0/mul_din1         multiplier operands (memory data passthrough)
//   mul_dout                  signed product
//   y_out/y_out_ap_vld        registered result and its valid pulse
module cnn_conv1_mac_ctrl
    import cnn_conv1_pkg::*;
#(
    parameter int NTAPS      = 9,
    parameter int ADDR_W     = 4,
    parameter int ACC_W      = 32,
    parameter int FRAC_SHIFT = 8,
    parameter int RELU       = 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [X_W-1:0]    bias,
    output logic [ADDR_W-1:0] x_address0,
    output logic              x_ce0,
    input  logic [X_W-1:0]    x_q0,
    output logic [ADDR_W-1:0] w_address0,
    output logic              w_ce0,
    input  logic [W_W-1:0]    w_q0,
    output logic [X_W-1:0]    mul_din0,
    output logic [W_W-1:0]    mul_din1,
    input  logic [P_W-1:0]    mul_dout,
    output logic [Y_W-1:0]    y_out,
    output logic              y_out_ap_vld
);

    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NTAPS - 1);
    localparam logic [ADDR_W:0]   CNT_DONE = (ADDR_W+1)'(NTAPS);

    state_t                  state;
    logic                    idle_r;
    logic                    done_r;
    logic                    ce_r;
    logic [ADDR_W-1:0]       addr_r;
    logic                    v_rd;     // memory data valid this cycle
    logic                    v_p;      // prod_r holds a tap product
    logic signed [P_W-1:0]   prod_r;
    logic signed [ACC_W-1:0] acc;
    logic [ADDR_W:0]         cnt;      // taps accumulated so far
    logic [Y_W-1:0]          y_r;
    logic [Y_W-1:0]          y_next;

    assign x_address0   = addr_r;
    assign w_address0   = addr_r;
    assign x_ce0        = ce_r;
    assign w_ce0        = ce_r;
    assign mul_din0     = x_q0;
    assign mul_din1     = w_q0;
    assign ap_idle      = idle_r;
    assign ap_done      = done_r;
    assign ap_ready     = done_r;
    assign y_out_ap_vld = done_r;
    assign y_out        = y_r;

    cnn_conv1_round_sat #(
        .ACC_W      (ACC_W),
        .FRAC_SHIFT (FRAC_SHIFT),
        .RELU       (RELU)
    ) u_round_sat (
        .acc (acc),
        .y   (y_next)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state  <= S_IDLE;
            idle_r <= 1'b1;
            done_r <= 1'b0;
            ce_r   <= 1'b0;
            addr_r <= '0;
            v_rd   <= 1'b0;
            v_p    <= 1'b0;
            prod_r <= '0;
            acc    <= '0;
            cnt    <= '0;
            y_r    <= '0;
        end else begin
            // Read -> multiply -> accumulate pipeline, one tap per stage.
            v_rd   <= ce_r;
            v_p    <= v_rd;
            done_r <= 1'b0;
            if (v_rd) begin
                prod_r <= signed'(mul_dout);
            end
            if (v_p) begin
                acc <= acc + ACC_W'(prod_r);
                cnt <= cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        state  <= S_RUN;
                        idle_r <= 1'b0;
                        ce_r   <= 1'b1;
                        addr_r <= '0;
                        cnt    <= '0;
                        acc    <= ACC_W'(signed'(bias)) <<< FRAC_SHIFT;
                    end
                end
                S_RUN: begin
                    if (addr_r == LAST_TAP) begin
                        ce_r   <= 1'b0;
                        addr_r <= '0;
                        state  <= S_DRAIN;
                    end else begin
                        addr_r <= addr_r + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == CNT_DONE) begin
                        y_r    <= y_next;
                        done_r <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    idle_r <= 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_conv1_mac_ctrl.sv
// tb_cnn_conv1_mac_ctrl
//   Drives two instances (ReLU on and off) from shared memories and bias,
//   and compares every cycle against a timeline/arithmetic model.
module tb_cnn_conv1_mac_ctrl;

    localparam int NTAPS = 9;
    localparam int ADDR_W = 4;
    localparam int ACC_W = 32;
    localparam int FRAC = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ap_start = 1'b0;
    logic signed [13:0] bias = '0;

    logic signed [13:0] xmem [16];
    logic signed [8:0]  wmem [16];

    logic done_r, idle_r, ready_r, vld_r, xce_r, wce_r;
    logic [ADDR_W-1:0] xa_r, wa_r;
    logic signed [13:0] xq_r, md0_r, y_r;
    logic signed [8:0]  wq_r, md1_r;
    logic signed [22:0] mdout_r;

    logic done_n, idle_n, ready_n, vld_n, xce_n, wce_n;
    logic [ADDR_W-1:0] xa_n, wa_n;
    logic signed [13:0] xq_n, md0_n, y_n;
    logic signed [8:0]  wq_n, md1_n;
    logic signed [22:0] mdout_n;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cnn_conv1_mac_ctrl #(.NTAPS(NTAPS), .ADDR_W(ADDR_W), .ACC_W(ACC_W),
                         .FRAC_SHIFT(FRAC), .RELU(1)) dut_r (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start),
        .ap_done(done_r), .ap_idle(idle_r), .ap_ready(ready_r), .bias(bias),
        .x_address0(xa_r), .x_ce0(xce_r), .x_q0(xq_r),
        .w_address0(wa_r), .w_ce0(wce_r), .w_q0(wq_r),
        .mul_din0(md0_r), .mul_din1(md1_r), .mul_dout(mdout_r),
        .y_out(y_r), .y_out_ap_vld(vld_r)
    );

    cnn_conv1_mac_ctrl #(.NTAPS(NTAPS), .ADDR_W(ADDR_W), .ACC_W(ACC_W),
                         .FRAC_SHIFT(FRAC), .RELU(0)) dut_n (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start),
        .ap_done(done_n), .ap_idle(idle_n), .ap_ready(ready_n), .bias(bias),
        .x_address0(xa_n), .x_ce0(xce_n), .x_q0(xq_n),
        .w_address0(wa_n), .w_ce0(wce_n), .w_q0(wq_n),
        .mul_din0(md0_n), .mul_din1(md1_n), .mul_dout(mdout_n),
        .y_out(y_n), .y_out_ap_vld(vld_n)
    );

    // Memories with 1-cycle read latency and the external multipliers.
    always @(posedge clk) begin
        if (xce_r) xq_r <= xmem[xa_r];
        if (wce_r) wq_r <= wmem[wa_r];
        if (xce_n) xq_n <= xmem[xa_n];
        if (wce_n) wq_n <= wmem[wa_n];
    end
    assign mdout_r = md0_r * md1_r;
    assign mdout_n = md0_n * md1_n;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected pixel from bias and memory contents, plain arithmetic.
    function automatic int expect_y(input bit relu);
        longint acc;
        longint r;
        acc = longint'(bias) * (longint'(1) <<< FRAC);
        for (int k = 0; k < NTAPS; k++) acc += longint'(xmem[k]) * longint'(wmem[k]);
        r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        if (r > 8191) r = 8191;
        if (r < -8192) r = -8192;
        if (relu && r < 0) r = 0;
        return int'(r);
    endfunction

    // Model timeline: m_t = cycle number within the operation (accept = 0).
    bit m_busy = 1'b0;
    int m_t = 0;
    int res_r = 0, res_n = 0;
    int yh_r = 0, yh_n = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_t    <= 0;
            yh_r   <= 0;
            yh_n   <= 0;
        end else if (m_busy) begin
            if (m_t == NTAPS + 4) begin
                m_busy <= 1'b0;
            end else begin
                m_t <= m_t + 1;
                if (m_t == NTAPS + 3) begin
                    yh_r <= res_r;
                    yh_n <= res_n;
                end
            end
        end else if (ap_start) begin
            m_busy <= 1'b1;
            m_t    <= 1;
            res_r  <= expect_y(1'b1);
            res_n  <= expect_y(1'b0);
        end
    end

    task automatic check_dut(input string tag, input logic idle, input logic done,
                             input logic ready, input logic vld, input logic xce,
                             input logic wce, input logic [ADDR_W-1:0] xa,
                             input logic [ADDR_W-1:0] wa, input logic signed [13:0] md0,
                             input logic signed [8:0] md1, input logic signed [13:0] y,
                             input int yexp);
        bit exp_ce;
        bit exp_done;
        exp_ce   = m_busy && m_t >= 1 && m_t <= NTAPS;
        exp_done = m_busy && m_t == NTAPS + 4;
        chk({tag, "_idle"}, idle, !m_busy);
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_ready"}, ready, exp_done);
        chk({tag, "_vld"}, vld, exp_done);
        chk({tag, "_x_ce"}, xce, exp_ce);
        chk({tag, "_w_ce"}, wce, exp_ce);
        if (exp_ce) begin
            chk({tag, "_x_addr"}, xa, m_t - 1);
            chk({tag, "_w_addr"}, wa, m_t - 1);
        end
        if (m_busy && m_t >= 2 && m_t <= NTAPS + 1) begin
            chk({tag, "_mul_din0"}, md0, xmem[m_t-2]);
            chk({tag, "_mul_din1"}, md1, wmem[m_t-2]);
        end
        chk({tag, "_y_out"}, y, yexp);
    endtask

    always @(negedge clk) begin
        check_dut("relu", idle_r, done_r, ready_r, vld_r, xce_r, wce_r, xa_r, wa_r,
                  md0_r, md1_r, y_r, yh_r);
        check_dut("norelu", idle_n, done_n, ready_n, vld_n, xce_n, wce_n, xa_n, wa_n,
                  md0_n, md1_n, y_n, yh_n);
    end

    task automatic load_all(input int xv, input int wv);
        for (int k = 0; k < 16; k++) begin
            xmem[k] = 14'(xv);
            wmem[k] = 9'(wv);
        end
    endtask

    task automatic load_tap4(input int xv, input int wv);
        load_all(0, 0);
        xmem[4] = 14'(xv);
        wmem[4] = 9'(wv);
    endtask

    task automatic run_op(input string nm, input int b, input int lit_r, input int lit_n);
        int cyc;
        bit seen;
        @(negedge clk);
        #1;
        bias = 14'(b);
        ap_start = 1'b1;
        @(posedge clk);
        #1;
        ap_start = 1'b0;
        cyc = 1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done_r) seen = 1'b1;
            else begin
                @(posedge clk);
                cyc++;
            end
        end
        chk({nm, "_done_seen"}, seen, 1);
        chk({nm, "_done_cycle"}, cyc, 13);
        chk({nm, "_y_relu"}, y_r, lit_r);
        chk({nm, "_y_norelu"}, y_n, lit_n);
        chk({nm, "_model_pin"}, res_r, lit_r);
    endtask

    initial begin
        if (ACC_W < 23 + $clog2(NTAPS) + 1) begin
            $display("FAIL acc_width: ACC_W %0d too small for %0d taps", ACC_W, NTAPS);
            $fatal(1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc, d1, d2, idle_between, done_cnt;
        load_all(0, 0);
        repeat (3) @(negedge clk);
        chk("reset_idle", idle_r, 1);
        chk("reset_done", done_r, 0);
        chk("reset_x_ce", xce_r, 0);
        chk("reset_y", y_r, 0);
        #1 rst_n = 1'b1;

        load_all(256, 64);
        run_op("basic", 0, 576, 576);
        run_op("bias", 2, 578, 578);
        load_tap4(1, 128);
        run_op("round_up", 0, 1, 1);
        load_tap4(1, 127);
        run_op("round_down", 0, 0, 0);
        load_all(8191, 255);
        run_op("saturate", 0, 8191, 8191);
        load_all(-256, 64);
        run_op("relu", 0, 0, -576);

        // Reset in cycle 5 of an operation.
        load_all(256, 64);
        @(negedge clk);
        #1;
        bias = '0;
        ap_start = 1'b1;
        @(posedge clk);
        #1;
        ap_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_idle", idle_r, 1);
        chk("midrst_x_ce", xce_r, 0);
        chk("midrst_w_ce", wce_r, 0);
        chk("midrst_idle_n", idle_n, 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_r || done_n) done_cnt++;
        end
        chk("midrst_no_done", done_cnt, 0);
        run_op("rerun", 0, 576, 576);

        // Back-to-back with ap_start held high.
        @(negedge clk);
        #1;
        bias = '0;
        ap_start = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1;
        d1 = -1;
        d2 = -1;
        idle_between = 0;
        for (int i = 0; i < 60 && d2 < 0; i++) begin
            @(negedge clk);
            if (done_r) begin
                if (d1 < 0) d1 = cyc;
                else d2 = cyc;
            end else if (d1 >= 0 && idle_r) begin
                idle_between++;
            end
            if (d2 >= 0) begin
                ap_start = 1'b0;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        ap_start = 1'b0;
        chk("b2b_first_done", d1, 13);
        chk("b2b_second_done", d2, 27);
        chk("b2b_idle_cycles", idle_between, 1);
        chk("b2b_y", y_r, 576);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/cnn_conv1_mac_ctrl.md
Name: cnn_conv1_mac_ctrl

Overview:
Sequencer that computes one conv1 output pixel as a dot product of NTAPS pixel/weight pairs through one shared 14s x 9s combinational multiplier. It fetches operands from pixel and weight memories, feeds the multiplier, registers and accumulates the products, adds the bias, then rounds, saturates and optionally applies ReLU. It sits between the conv1 loop controller, which uses the ap_start/ap_done handshake, and the multiplier instance, which sits outside this block.

Parameters:
NTAPS, 9, number of taps per output pixel (3x3 kernel, depth 1)
ADDR_W, 4, tap address width; must satisfy 2**ADDR_W >= NTAPS
ACC_W, 32, accumulator width
FRAC_SHIFT, 8, fractional bits removed at output; must be >= 1
RELU, 1, 1 = clamp negative results to 0

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
ap_start  in  1  start request, sampled in IDLE
ap_done  out  1  one-cycle pulse, result valid
ap_idle  out  1  high in IDLE
ap_ready  out  1  one-cycle pulse, coincident with ap_done
bias  in  14  signed bias, sampled when start is accepted
x_address0  out  ADDR_W  pixel memory address
x_ce0  out  1  pixel memory read enable
x_q0  in  14  signed pixel; 1-cycle read latency
w_address0  out  ADDR_W  weight memory address
w_ce0  out  1  weight memory read enable
w_q0  in  9  signed weight; 1-cycle read latency
mul_din0  out  14  multiplier operand a (= x_q0)
mul_din1  out  9  multiplier operand b (= w_q0)
mul_dout  in  23  signed product from the combinational multiplier
y_out  out  14  signed result, registered
y_out_ap_vld  out  1  high together with ap_done

Behaviour:
- Reset is async and active-low; it may be applied at any time, including mid-operation.
- Reset values: state=IDLE, ap_idle=1, every other output 0, accumulator and counters 0, pipeline valid bits 0.
- States:
  - IDLE: wait for ap_start.
  - RUN: issue the NTAPS tap reads.
  - DRAIN: let the pipeline empty.
  - DONE: present the result.
- Transitions:
  - IDLE->RUN on ap_start=1.
  - RUN->DRAIN after tap NTAPS-1 is issued.
  - DRAIN->DONE when the accumulated-tap count reaches NTAPS.
  - DONE->IDLE unconditionally. A new start is accepted only in IDLE.
- Timing, with the cycle in which ap_start is accepted numbered 0:
  - End of cycle 0: acc <= sign_extend(bias) <<< FRAC_SHIFT.
  - Cycles 1..NTAPS: x_ce0=w_ce0=1, x_address0=w_address0=k for tap k (k = cycle-1). Both enables are 0 in every other cycle.
  - Cycle k+2: x_q0/w_q0 of tap k are valid. mul_din0/mul_din1 are driven straight from them. mul_dout is registered into prod_r at the end of the cycle, with valid bit v_p set.
  - End of cycle k+3: acc <= acc + sign_extend(prod_r); accumulated-tap count increments.
  - End of cycle NTAPS+3: y_out is registered and state goes to DONE.
  - Cycle NTAPS+4 (13 for the defaults): ap_done=ap_ready=y_out_ap_vld=1 for exactly one cycle.
- Output arithmetic:
  - r = (acc + 2**(FRAC_SHIFT-1)) >>> FRAC_SHIFT (round half up).
  - Saturate r to [-8192, 8191].
  - If RELU=1 and r<0, the result is 0.
- y_out holds its value after DONE until the next DONE or a reset.
- The accumulator must not overflow: 9 x (2**22) plus the bias fits in 32 bits. The bench asserts ACC_W >= 23 + clog2(NTAPS) + 1.
- ap_start held high through a whole operation starts a second operation in the cycle after DONE returns to IDLE.
- A reset during RUN/DRAIN: no ap_done, ce drops immediately, the result is discarded.

Decomposition:
- Package cnn_conv1_pkg:
  - state encoding constants (IDLE/RUN/DRAIN/DONE);
  - OUT_MAX = 8191 and OUT_MIN = -8192;
  - operand widths 14/9/23.
- One sub-module, cnn_conv1_round_sat: combinational round, saturate and ReLU from ACC_W to 14 bits, parameterised by FRAC_SHIFT and RELU. This lets it be unit-tested in isolation.

Test Plan:
- Basic: x=256 and w=64 for all taps, bias=0 -> addresses 0..8 seen in cycles 1..9, ap_done in cycle 13, y_out=576.
- Bias: same data, bias=2 -> y_out=578.
- Rounding: only tap 4 nonzero, x=1 and w=128 -> y_out=1. With w=127 -> y_out=0.
- Saturation and ReLU: x=8191, w=255 on all taps -> y_out=8191. x=-256, w=64 -> y_out=0 when RELU=1, -576 when RELU=0.
- Reset mid-op: ap_rst_n low in cycle 5 -> immediately ap_idle=1, x_ce0=0, no ap_done. Rerun of the Basic case -> y_out=576 at the correct cycle.
- Back-to-back: ap_start held high -> two operations with ap_done 14 cycles apart. ap_idle=1 exactly one cycle between them.
